// File: rtl/tt_scanner_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } ttState_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/tt_lookup.sv
// Combinational truth-table lookup: s = tt[sel], bit i of tt is the output for input vector i.
module tt_lookup #(
  parameter int N_IN = 4
) (
  input  logic [2**N_IN-1:0] tt,
  input  logic [N_IN-1:0]    sel,
  output logic               s
);

  assign s = tt[sel];

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: evaluates one input vector or sweeps all of them with a valid/ready output.
// Optional macro TT_PARITY_EN adds a 'parity' output (XOR of accepted s values since start).
module truth_table_scanner
  import tt_scanner_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = 2**N_IN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] x,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_x,
  output logic            s,
  output logic [N_IN:0]   ones,
  output logic            done
`ifdef TT_PARITY_EN
  ,
  output logic            parity
`endif
);

  localparam logic [N_IN-1:0] IdxOne  = N_IN'(1);
  localparam logic [N_IN-1:0] IdxLast = '1;

  ttState_e        stateQ, stateD;
  logic [TT_W-1:0] ttQ, ttD;
  logic            modeQ, modeD;
  logic [N_IN-1:0] idxQ, idxD;
  logic            busyQ, busyD;
  logic            validQ, validD;
  logic [N_IN-1:0] outXQ, outXD;
  logic            sQ, sD;
  logic [N_IN:0]   onesQ, onesD;
  logic            doneQ, doneD;
`ifdef TT_PARITY_EN
  logic            parityQ, parityD;
`endif

  logic [N_IN-1:0] lookupSel;
  logic            lookupS;

  // In HOLD the mux looks one index ahead so the next result is ready on acceptance.
  assign lookupSel = (stateQ == HOLD) ? idxQ + IdxOne : idxQ;

  tt_lookup #(
    .N_IN (N_IN)
  ) uLookup (
    .tt  (ttQ),
    .sel (lookupSel),
    .s   (lookupS)
  );

  always_comb begin
    stateD  = stateQ;
    ttD     = ttQ;
    modeD   = modeQ;
    idxD    = idxQ;
    busyD   = busyQ;
    validD  = validQ;
    outXD   = outXQ;
    sD      = sQ;
    onesD   = onesQ;
    doneD   = 1'b0;
`ifdef TT_PARITY_EN
    parityD = parityQ;
`endif
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          ttD     = tt;
          modeD   = mode;
          idxD    = (mode == MODE_SWEEP) ? '0 : x;
          onesD   = '0;
          busyD   = 1'b1;
          stateD  = EVAL;
`ifdef TT_PARITY_EN
          parityD = 1'b0;
`endif
        end
      end
      EVAL: begin
        validD = 1'b1;
        outXD  = idxQ;
        sD     = lookupS;
        stateD = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          onesD   = onesQ + {{N_IN{1'b0}}, sQ};
`ifdef TT_PARITY_EN
          parityD = parityQ ^ sQ;
`endif
          if (modeQ == MODE_SINGLE || idxQ == IdxLast) begin
            validD = 1'b0;
            busyD  = 1'b0;
            doneD  = 1'b1;
            stateD = FIN;
          end else begin
            idxD  = lookupSel;
            outXD = lookupSel;
            sD    = lookupS;
          end
        end
      end
      FIN: begin
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= IDLE;
      ttQ     <= '0;
      modeQ   <= MODE_SINGLE;
      idxQ    <= '0;
      busyQ   <= 1'b0;
      validQ  <= 1'b0;
      outXQ   <= '0;
      sQ      <= 1'b0;
      onesQ   <= '0;
      doneQ   <= 1'b0;
`ifdef TT_PARITY_EN
      parityQ <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      ttQ     <= ttD;
      modeQ   <= modeD;
      idxQ    <= idxD;
      busyQ   <= busyD;
      validQ  <= validD;
      outXQ   <= outXD;
      sQ      <= sD;
      onesQ   <= onesD;
      doneQ   <= doneD;
`ifdef TT_PARITY_EN
      parityQ <= parityD;
`endif
    end
  end

  assign busy      = busyQ;
  assign out_valid = validQ;
  assign out_x     = outXQ;
  assign s         = sQ;
  assign ones      = onesQ;
  assign done      = doneQ;
`ifdef TT_PARITY_EN
  assign parity    = parityQ;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner with a result scoreboard (N_IN=4 and N_IN=1 instances).
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mode, outReady;
  logic [15:0] tt;
  logic [3:0]  x;
  logic        busy, outValid, s, done;
  logic [3:0]  outX;
  logic [4:0]  ones;

  logic        start1, mode1, ready1;
  logic [1:0]  tt1;
  logic [0:0]  x1;
  logic        busy1, valid1, s1, done1;
  logic [0:0]  outX1;
  logic [1:0]  ones1;
`ifdef TT_PARITY_EN
  logic        parity, parity1;
`endif

  truth_table_scanner #(.N_IN(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .tt(tt), .x(x),
    .busy(busy), .out_valid(outValid), .out_ready(outReady), .out_x(outX), .s(s),
    .ones(ones), .done(done)
`ifdef TT_PARITY_EN
    , .parity(parity)
`endif
  );

  truth_table_scanner #(.N_IN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .tt(tt1), .x(x1),
    .busy(busy1), .out_valid(valid1), .out_ready(ready1), .out_x(outX1), .s(s1),
    .ones(ones1), .done(done1)
`ifdef TT_PARITY_EN
    , .parity(parity1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int doneCnt = 0;
  logic [4:0] expQ[$];
  logic [1:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set: score any handshake due at the next posedge.
  task automatic tick();
    logic [4:0] e;
    logic [1:0] e1;
    if (outValid && outReady) begin
      if (expQ.size() == 0) chk("unexpected_result", outValid, 1'b0);
      else begin
        e = expQ.pop_front();
        chk("out_x", outX, e[4:1]);
        chk("s", s, e[0]);
      end
    end
    if (valid1 && ready1) begin
      if (q1.size() == 0) chk("unexpected_result1", valid1, 1'b0);
      else begin
        e1 = q1.pop_front();
        chk("out_x1", outX1, e1[1]);
        chk("s1", s1, e1[0]);
      end
    end
    @(negedge clk);
    if (done) doneCnt++;
  endtask

  task automatic pushSweep(input logic [15:0] t);
    for (int i = 0; i < 16; i++) expQ.push_back({i[3:0], t[i]});
  endtask

  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  task automatic seekX(input logic [3:0] target);
    for (int i = 0; i < 30 && !(outValid && outX == target); i++) tick();
    chk("seek_out_x", outX, target);
  endtask

  int n;
  int doneBefore;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; outReady = 1'b0; tt = '0; x = '0;
    start1 = 1'b0; mode1 = 1'b0; ready1 = 1'b0; tt1 = '0; x1 = '0;
    @(negedge clk);
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", outValid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ones", ones, 5'd0);
    chk("rst_out_x", outX, 4'd0);
    chk("rst_s", s, 1'b0);
    reset = 1'b0;
    tick();

    // Full sweep at full throughput; tt changes after start must be ignored.
    tt = 16'hAC3C; mode = 1'b1; outReady = 1'b1; start = 1'b1;
    pushSweep(16'hAC3C);
    tick();
    start = 1'b0; tt = 16'h0000;
    chk("busy_after_start", busy, 1'b1);
    chk("valid_in_eval", outValid, 1'b0);
    tick();
    chk("first_valid", outValid, 1'b1);
    chk("first_out_x", outX, 4'd0);
    waitDone(40, n);
    chk("sweep_cycles", n, 16);
    chk("sweep_ones", ones, 5'd8);
    chk("busy_at_done", busy, 1'b0);
    chk("valid_at_done", outValid, 1'b0);
    chk("sweep_sb_empty", expQ.size(), 0);
`ifdef TT_PARITY_EN
    chk("sweep_parity", parity, 1'b0);
`endif
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("ones_held", ones, 5'd8);

    // Single evaluation.
    tt = 16'hAC3C; mode = 1'b0; x = 4'b0110; start = 1'b1;
    expQ.push_back({4'd6, 1'b0});
    tick();
    start = 1'b0; x = 4'd0;
    tick();
    waitDone(10, n);
    chk("single_cycles", n, 1);
    chk("single_ones", ones, 5'd0);
    chk("single_sb_empty", expQ.size(), 0);
    tick();

    // Backpressure at out_x=5.
    tt = 16'hAC3C; mode = 1'b1; start = 1'b1;
    pushSweep(16'hAC3C);
    tick();
    start = 1'b0;
    tick();
    seekX(4'd5);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", outValid, 1'b1);
      chk("bp_out_x", outX, 4'd5);
      chk("bp_s", s, 1'b1);
    end
    outReady = 1'b1;
    waitDone(40, n);
    chk("bp_ones", ones, 5'd8);
    chk("bp_sb_empty", expQ.size(), 0);
    tick();

    // Reset mid-sweep at out_x=9.
    start = 1'b1;
    pushSweep(16'hAC3C);
    tick();
    start = 1'b0;
    tick();
    seekX(4'd9);
    doneBefore = doneCnt;
    reset = 1'b1;
    tick();
    expQ.delete();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", outValid, 1'b0);
    chk("mid_rst_ones", ones, 5'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_done", doneCnt, doneBefore);

    // Start while busy is ignored.
    tt = 16'hAC3C; mode = 1'b1; start = 1'b1;
    pushSweep(16'hAC3C);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tt = 16'hFFFF; mode = 1'b0; x = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(40, n);
    chk("busy_start_ones", ones, 5'd8);
    chk("busy_start_sb_empty", expQ.size(), 0);
    tick();

    // N_IN=1 sweep.
    tt1 = 2'b10; mode1 = 1'b1; ready1 = 1'b1; start1 = 1'b1;
    q1.push_back({1'b0, 1'b0});
    q1.push_back({1'b1, 1'b1});
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      tick();
      n++;
    end
    chk("n1_done_cycles", n, 3);
    chk("n1_ones", ones1, 2'd1);
    chk("n1_sb_empty", q1.size(), 0);
`ifdef TT_PARITY_EN
    chk("n1_parity", parity1, 1'b1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
